// File: rtl/sd_cmd_host.sv
// rtl/sd_cmd_host.sv - SD CMD-line host engine: command serialiser, response collector, mc_clk generator
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   start                    begin a transaction (only honoured while idle)
//   cmd_idx, cmd_arg         command index / argument, sampled with start
//   resp_type                0 none, 1 short (48b), 2 long (136b), 3 treated as none
//   resp_nocrc               skip response CRC check, sampled with start
//   busy, done               transaction in progress / one-cycle completion pulse
//   resp                     captured response, cleared by the next start
//   crc_err, timeout         response status, valid with done, held until next start
//   mc_clk_o                 SD clock to the pad
//   mc_cmd_o, mc_cmd_oe      CMD output data / output enable (line pulled up when released)
//   mc_cmd_i                 CMD input from the pad
module sd_cmd_host #(
  parameter int CLK_DIV = 2,
  parameter int NCR_MAX = 64,
  parameter int NCC     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [5:0]   cmd_idx,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  input  logic         resp_nocrc,
  output logic         busy,
  output logic         done,
  output logic [127:0] resp,
  output logic         crc_err,
  output logic         timeout,
  output logic         mc_clk_o,
  output logic         mc_cmd_o,
  output logic         mc_cmd_oe,
  input  logic         mc_cmd_i
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam int CMAX = (NCR_MAX > NCC) ? NCR_MAX : NCC;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT,
    ST_RX,
    ST_TAIL
  } state_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      c = crc7_step(c, d[i]);
    end
    return c;
  endfunction

  // Free-running SD clock divider
  logic [DW-1:0] div_cnt_q;
  logic          mc_clk_q;
  logic          tick, rise_tick, fall_tick;

  assign tick      = (div_cnt_q == DIV_LAST);
  assign rise_tick = tick && !mc_clk_q;
  assign fall_tick = tick && mc_clk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      mc_clk_q  <= 1'b0;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
      if (tick) begin
        mc_clk_q <= !mc_clk_q;
      end
    end
  end

  state_t         state_q, state_d;
  logic [47:0]    frame_q, frame_d;
  logic [5:0]     tx_cnt_q, tx_cnt_d;
  logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]     rx_cnt_q, rx_cnt_d;
  logic [6:0]     crc_q, crc_d;
  logic           long_q, long_d;
  logic           has_resp_q, has_resp_d;
  logic           nocrc_q, nocrc_d;
  logic [127:0]   resp_q, resp_d;
  logic           crc_err_q, crc_err_d;
  logic           timeout_q, timeout_d;
  logic           cmd_o_q, cmd_o_d;
  logic           cmd_oe_q, cmd_oe_d;
  logic           done_q, done_d;

  logic [39:0]    tx_payload;
  logic [6:0]     tx_crc;
  logic [7:0]     rx_last, crc_lo, crc_hi;
  logic [127:0]   rx_resp_shift;
  logic [6:0]     rx_crc_upd;

  assign tx_payload = {1'b0, 1'b1, cmd_idx, cmd_arg};
  assign tx_crc     = crc7_40(tx_payload);

  // Long responses exclude the start, transmission and reserved bits from the CRC,
  // so the CRC window starts at the 9th received bit.
  assign rx_last = long_q ? 8'd135 : 8'd47;
  assign crc_lo  = long_q ? 8'd8   : 8'd0;
  assign crc_hi  = long_q ? 8'd128 : 8'd40;

  // resp is used directly as the receive shift register; for a long frame the
  // leading 8 bits fall off the top, for a short one the upper bits stay zero.
  assign rx_resp_shift = {resp_q[126:0], mc_cmd_i};
  assign rx_crc_upd    = ((rx_cnt_q >= crc_lo) && (rx_cnt_q < crc_hi)) ?
                         crc7_step(crc_q, mc_cmd_i) : crc_q;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    tx_cnt_d   = tx_cnt_q;
    wait_cnt_d = wait_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    crc_d      = crc_q;
    long_d     = long_q;
    has_resp_d = has_resp_q;
    nocrc_d    = nocrc_q;
    resp_d     = resp_q;
    crc_err_d  = crc_err_q;
    timeout_d  = timeout_q;
    cmd_o_d    = cmd_o_q;
    cmd_oe_d   = cmd_oe_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_oe_d = 1'b0;
        // done_q high means this is the completion cycle; a start here is dropped
        if (start && !done_q) begin
          frame_d    = {tx_payload, tx_crc, 1'b1};
          tx_cnt_d   = 6'd48;
          long_d     = (resp_type == 2'd2);
          has_resp_d = (resp_type == 2'd1) || (resp_type == 2'd2);
          nocrc_d    = resp_nocrc;
          resp_d     = '0;
          crc_err_d  = 1'b0;
          timeout_d  = 1'b0;
          state_d    = ST_TX;
        end
      end

      ST_TX: begin
        if (fall_tick) begin
          if (tx_cnt_q != 6'd0) begin
            cmd_oe_d = 1'b1;
            cmd_o_d  = frame_q[47];
            frame_d  = {frame_q[46:0], 1'b0};
            tx_cnt_d = tx_cnt_q - 6'd1;
          end else begin
            // end bit has been on the line for a full period; release the line
            cmd_oe_d   = 1'b0;
            cmd_o_d    = 1'b1;
            wait_cnt_d = '0;
            rx_cnt_d   = 8'd0;
            crc_d      = 7'h00;
            state_d    = has_resp_q ? ST_WAIT : ST_TAIL;
          end
        end
      end

      ST_WAIT: begin
        if (rise_tick) begin
          if (!mc_cmd_i) begin
            resp_d   = rx_resp_shift;
            crc_d    = rx_crc_upd;
            rx_cnt_d = 8'd1;
            state_d  = ST_RX;
          end else if (int'(wait_cnt_q) + 1 >= NCR_MAX) begin
            timeout_d  = 1'b1;
            wait_cnt_d = '0;
            state_d    = ST_TAIL;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end

      ST_RX: begin
        if (rise_tick) begin
          resp_d   = rx_resp_shift;
          crc_d    = rx_crc_upd;
          rx_cnt_d = rx_cnt_q + 8'd1;
          if (rx_cnt_q == rx_last) begin
            crc_err_d  = !nocrc_q && (crc_q != rx_resp_shift[7:1]);
            wait_cnt_d = '0;
            state_d    = ST_TAIL;
          end
        end
      end

      ST_TAIL: begin
        cmd_oe_d = 1'b0;
        if (rise_tick) begin
          if (int'(wait_cnt_q) + 1 >= NCC) begin
            wait_cnt_d = '0;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        cmd_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      tx_cnt_q   <= '0;
      wait_cnt_q <= '0;
      rx_cnt_q   <= '0;
      crc_q      <= '0;
      long_q     <= 1'b0;
      has_resp_q <= 1'b0;
      nocrc_q    <= 1'b0;
      resp_q     <= '0;
      crc_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
      cmd_o_q    <= 1'b1;
      cmd_oe_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      tx_cnt_q   <= tx_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      crc_q      <= crc_d;
      long_q     <= long_d;
      has_resp_q <= has_resp_d;
      nocrc_q    <= nocrc_d;
      resp_q     <= resp_d;
      crc_err_q  <= crc_err_d;
      timeout_q  <= timeout_d;
      cmd_o_q    <= cmd_o_d;
      cmd_oe_q   <= cmd_oe_d;
      done_q     <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign resp      = resp_q;
  assign crc_err   = crc_err_q;
  assign timeout   = timeout_q;
  assign mc_clk_o  = mc_clk_q;
  assign mc_cmd_o  = cmd_o_q;
  assign mc_cmd_oe = cmd_oe_q;

endmodule

// File: tb/tb_sd_cmd_host.sv
// tb/tb_sd_cmd_host.sv - self-checking bench for sd_cmd_host with a behavioural SD card on the CMD line
module tb_sd_cmd_host;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [5:0]   cmd_idx = '0;
  logic [31:0]  cmd_arg = '0;
  logic [1:0]   resp_type = '0;
  logic         resp_nocrc = 1'b0;
  logic         busy, done;
  logic [127:0] resp;
  logic         crc_err, timeout;
  logic         mc_clk_o, mc_cmd_o, mc_cmd_oe;
  logic         mc_cmd_i = 1'b1;

  sd_cmd_host #(.CLK_DIV(2), .NCR_MAX(64), .NCC(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cmd_idx    (cmd_idx),
    .cmd_arg    (cmd_arg),
    .resp_type  (resp_type),
    .resp_nocrc (resp_nocrc),
    .busy       (busy),
    .done       (done),
    .resp       (resp),
    .crc_err    (crc_err),
    .timeout    (timeout),
    .mc_clk_o   (mc_clk_o),
    .mc_cmd_o   (mc_cmd_o),
    .mc_cmd_oe  (mc_cmd_oe),
    .mc_cmd_i   (mc_cmd_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [47:0]  frame;
    logic [127:0] resp;
    logic         crc_err;
    logic         timeout;
    int           rises;
  } exp_t;

  exp_t        exp_q[$];
  logic [47:0] frames_q[$];

  // Card model state
  logic [135:0] card_frame = '0;
  int           card_len = 0;
  int           tx_left = 0;
  int           tx_wait = 0;
  logic [47:0]  cap_sr = '0;
  int           cap_cnt = 0;
  int           rise_total = 0;
  int           first_rise = 0;
  int           done_cnt = 0;
  logic         prev_clk = 1'b0;

  function automatic logic [6:0] crc7_n(input logic [119:0] d, input int n);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = n - 1; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  // Card: samples host bits on mc_clk rising, drives its response on mc_clk falling
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        cap_cnt  = 0;
        tx_left  = 0;
        mc_cmd_i = 1'b1;
        prev_clk = mc_clk_o;
      end else begin
        if (done) done_cnt++;
        if (!prev_clk && mc_clk_o) begin
          rise_total++;
          if (mc_cmd_oe) begin
            cap_sr = {cap_sr[46:0], mc_cmd_o};
            cap_cnt++;
            if (cap_cnt == 1) first_rise = rise_total;
            if (cap_cnt == 48) begin
              frames_q.push_back(cap_sr);
              cap_cnt = 0;
              if (card_len != 0) begin
                tx_left = card_len;
                tx_wait = 2;
              end
            end
          end
        end
        if (prev_clk && !mc_clk_o) begin
          if (tx_left > 0 && tx_wait > 0) begin
            tx_wait--;
            mc_cmd_i = 1'b1;
          end else if (tx_left > 0) begin
            mc_cmd_i = card_frame[tx_left-1];
            tx_left--;
          end else begin
            mc_cmd_i = 1'b1;
          end
        end
        prev_clk = mc_clk_o;
      end
    end
  end

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_txn(input string name, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rtype, input logic nocrc,
                         input int clen, input logic [135:0] cframe,
                         input logic [47:0] e_frame, input logic [127:0] e_resp,
                         input logic e_crc, input logic e_to, input int e_rises,
                         input bit poke, input bit start_at_done);
    exp_t        e;
    exp_t        got_e;
    logic [47:0] f;
    bit          ok;
    e.frame = e_frame; e.resp = e_resp; e.crc_err = e_crc; e.timeout = e_to; e.rises = e_rises;
    card_len   = clen;
    card_frame = cframe;
    @(negedge clk);
    cmd_idx = idx; cmd_arg = arg; resp_type = rtype; resp_nocrc = nocrc;
    start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    #1;
    check({name, ".busy_rise"}, busy, 1'b1);
    if (poke) begin
      repeat (40) @(negedge clk);
      cmd_idx = 6'h37; cmd_arg = 32'hDEADBEEF; resp_type = 2'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(ok);
    check({name, ".done_seen"}, ok, 1'b1);
    got_e = exp_q.pop_front();
    if (frames_q.size() > 0) begin
      f = frames_q.pop_front();
      check({name, ".frame"}, f, got_e.frame);
    end else begin
      check({name, ".frame_present"}, 1'b0, 1'b1);
    end
    check({name, ".resp"}, resp, got_e.resp);
    check({name, ".crc_err"}, crc_err, got_e.crc_err);
    check({name, ".timeout"}, timeout, got_e.timeout);
    check({name, ".rises"}, rise_total - first_rise + 1, got_e.rises);
    check({name, ".oe_at_done"}, mc_cmd_oe, 1'b0);
    check({name, ".busy_at_done"}, busy, 1'b0);
    if (start_at_done) begin
      cmd_idx = 6'd1; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    check({name, ".done_1cyc"}, done, 1'b0);
    check({name, ".busy_after"}, busy, 1'b0);
    check({name, ".resp_hold"}, resp, got_e.resp);
    card_len = 0;
    repeat (5) @(negedge clk);
  endtask

  logic [119:0] cid_body;
  logic [135:0] cid_frame;
  bit           ok_w;
  int           dc;

  initial begin
    cid_body  = 120'h03_5344_5344_3038_80_1234_5678_0123_AB;
    cid_frame = {2'b00, 6'h3F, cid_body, crc7_n(cid_body, 120), 1'b1};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.mc_clk", mc_clk_o, 1'b0);
    check("rst.cmd_o", mc_cmd_o, 1'b1);
    check("rst.oe", mc_cmd_oe, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.resp", resp, 128'h0);
    check("rst.crc_err", crc_err, 1'b0);
    check("rst.timeout", timeout, 1'b0);

    run_txn("cmd0", 6'd0, 32'h0, 2'd0, 1'b0, 0, '0,
            48'h400000000095, 128'h0, 1'b0, 1'b0, 56, 1'b0, 1'b0);
    run_txn("cmd8", 6'd8, 32'h1AA, 2'd1, 1'b0, 48, 136'h08000001AA13,
            48'h48000001AA87, 128'h08000001AA13, 1'b0, 1'b0, 106, 1'b0, 1'b0);
    run_txn("crcbad", 6'd8, 32'h1AA, 2'd1, 1'b0, 48, 136'h08000001AA15,
            48'h48000001AA87, 128'h08000001AA15, 1'b1, 1'b0, 106, 1'b0, 1'b0);
    run_txn("nocrc", 6'd8, 32'h1AA, 2'd1, 1'b1, 48, 136'h08000001AA15,
            48'h48000001AA87, 128'h08000001AA15, 1'b0, 1'b0, 106, 1'b0, 1'b0);
    run_txn("tmo", 6'd8, 32'h1AA, 2'd1, 1'b0, 0, '0,
            48'h48000001AA87, 128'h0, 1'b0, 1'b1, 120, 1'b0, 1'b0);
    run_txn("cid", 6'd2, 32'h0, 2'd2, 1'b0, 136, cid_frame,
            48'h42000000004D, cid_frame[127:0], 1'b0, 1'b0, 194, 1'b0, 1'b0);
    run_txn("rtype3", 6'd55, 32'h0, 2'd3, 1'b0, 0, '0,
            48'h770000000065, 128'h0, 1'b0, 1'b0, 56, 1'b0, 1'b0);
    run_txn("poke", 6'd8, 32'h1AA, 2'd1, 1'b0, 48, 136'h08000001AA13,
            48'h48000001AA87, 128'h08000001AA13, 1'b0, 1'b0, 106, 1'b1, 1'b0);
    run_txn("sad", 6'd0, 32'h0, 2'd0, 1'b0, 0, '0,
            48'h400000000095, 128'h0, 1'b0, 1'b0, 56, 1'b0, 1'b1);
    repeat (300) @(negedge clk);
    check("sad.no_extra_frame", frames_q.size(), 0);

    // Reset in the middle of TX
    dc = done_cnt;
    @(negedge clk);
    cmd_idx = 6'd17; cmd_arg = 32'h1234; resp_type = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok_w = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (cap_cnt == 20) begin
        ok_w = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rstmid.bit20", ok_w, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid.oe", mc_cmd_oe, 1'b0);
    check("rstmid.busy", busy, 1'b0);
    check("rstmid.mc_clk", mc_clk_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    check("rstmid.no_done", done_cnt, dc);
    check("rstmid.no_frame", frames_q.size(), 0);

    run_txn("post_rst", 6'd0, 32'h0, 2'd0, 1'b0, 0, '0,
            48'h400000000095, 128'h0, 1'b0, 1'b0, 56, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_cmd_host.md
# sd_cmd_host

Host-side SD card CMD-line engine for the photoframe SoC: it serialises 48-bit SD commands with CRC7 onto `mc_cmd` and generates `mc_clk`. It collects the card's 48-bit or 136-bit response, checks the response CRC7, and reports timeout. It is the initiator counterpart of the SD card model on the `mc_clk`/`mc_cmd` pads. A CPU-facing register wrapper drives it, and the `mc_dat` data path is a separate block.

## Interface
- `CLK_DIV`, default 2: half-period of `mc_clk` in `clk` cycles; `mc_clk` = `clk` / (2·CLK_DIV); must be ≥ 1.
- `NCR_MAX`, default 64: response start-bit timeout, in `mc_clk` periods.
- `NCC`, default 8: idle `mc_clk` periods appended after each transaction.
- `clk` in 1: system clock. One clock only.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a transaction; honoured only when `busy`=0.
- `cmd_idx` in 6: command index; sampled with `start`.
- `cmd_arg` in 32: command argument; sampled with `start`.
- `resp_type` in 2: response type. 0 = none, 1 = short (48 bit), 2 = long (136 bit), 3 = reserved (treated as 0).
- `resp_nocrc` in 1: skip the response CRC check (R3); sampled with `start`.
- `busy` out 1: a transaction is in progress.
- `done` out 1: one-cycle pulse at the end of a transaction.
- `resp` out 128: captured response; holds its value until the next `start`.
- `crc_err` out 1: response CRC mismatch; valid with `done`, held until the next `start`.
- `timeout` out 1: no start bit within NCR_MAX; valid with `done`, held until the next `start`.
- `mc_clk_o` out 1: SD clock to the pad.
- `mc_cmd_o` out 1: CMD output data.
- `mc_cmd_oe` out 1: CMD output enable. The pad tristates when this is 0; the line is pulled up externally.
- `mc_cmd_i` in 1: CMD input from the pad.

## Operation
- **SD clock.** A divider runs continuously from reset.
  - `mc_clk_o` toggles every CLK_DIV cycles.
  - "Fall tick" is the cycle in which `mc_clk_o` goes 1→0. "Rise tick" is the cycle in which it goes 0→1.
  - Outputs change only on fall ticks. `mc_cmd_i` is sampled only on rise ticks.
- **Command frame**, MSB first, 48 bits: `0`, `1`, `cmd_idx[5:0]`, `cmd_arg[31:0]`, `CRC7[6:0]`, `1`.
  - CRC7 polynomial is x^7+x^3+1, initial value 0, computed over the first 40 bits.
- **States:** IDLE → TX → (WAIT_RESP → RX) → TAIL → IDLE.
- **IDLE**
  - `mc_cmd_oe`=0, `busy`=0.
  - On `start`: latch the inputs, clear `crc_err`/`timeout`/`resp`, set `busy`, go to TX.
- **TX**
  - On the next fall tick, assert `mc_cmd_oe` and drive bit 47; one bit per fall tick afterwards.
  - After bit 0 (the end bit) has been driven for one full `mc_clk` period, deassert `mc_cmd_oe` on the following fall tick.
  - Then go to TAIL if `resp_type` is 0/3, otherwise to WAIT_RESP.
- **WAIT_RESP**
  - Counts rise ticks.
  - A `mc_cmd_i`=0 sample is the start bit: go to RX with that bit counted.
  - If NCR_MAX rise ticks pass with no 0 sample, set `timeout` and go to TAIL.
- **RX**
  - Shift in one bit per rise tick, 48 or 136 bits total including the start bit.
  - Short response: `resp[47:0]` holds the frame, `resp[127:48]`=0. CRC7 covers frame bits 47:8 and is compared with bits 7:1.
  - Long response: `resp[127:0]` holds frame bits 127:0. CRC7 covers frame bits 127:8 and is compared with bits 7:1.
  - After the last bit, set `crc_err` if the CRC mismatches and `resp_nocrc`=0. Go to TAIL.
- **TAIL**
  - Wait NCC rise ticks with `mc_cmd_oe`=0.
  - Then pulse `done` for one cycle, clear `busy` in the same cycle, and go to IDLE.
- **Boundary conditions**
  - `start` while `busy`=1 is ignored and its inputs are not latched.
  - `start` in the same cycle as `done` is ignored.
  - `rst` mid-transaction returns to IDLE immediately: no `done`, `mc_cmd_oe`=0, divider restarted.
  - The end bit and transmission bit of the response are stored but not checked.

## Timing
- **Reset values:** `mc_clk_o`=0, `mc_cmd_o`=1, `mc_cmd_oe`=0, `busy`=0, `done`=0, `resp`=0, `crc_err`=0, `timeout`=0, divider count 0.
- After reset release, the first rise tick occurs at cycle CLK_DIV.
- `busy` rises the cycle after `start` is sampled.
- The first command bit appears at the first fall tick after that, so the delay is at most 2·CLK_DIV cycles.
- Each bit lasts 2·CLK_DIV cycles. TX occupies 48·2·CLK_DIV cycles, which is 192 cycles at the default.
- No-response transaction: from the first bit to `done` is (48+NCC)·2·CLK_DIV cycles, ±CLK_DIV.
- `done` is asserted exactly one cycle. `resp`, `crc_err` and `timeout` are stable from that cycle on.

## Test plan
- **CMD0, no response.** `cmd_idx`=0, `cmd_arg`=0, `resp_type`=0 → the line carries 0x400000000095, then `mc_cmd_oe`=0. `done` arrives after 56 `mc_clk` periods; `crc_err`=0, `timeout`=0.
- **CMD8, short response.** `cmd_idx`=8, `cmd_arg`=0x1AA, `resp_type`=1, against the SD model → the frame sent is 0x48000001AA87. `resp[47:0]`=0x08000001AA13 (R7 echo), `crc_err`=0.
- **CRC error.** Bench responds 0x08000001AA15 (bad CRC) → `crc_err`=1 on `done`. Repeat with `resp_nocrc`=1 → `crc_err`=0.
- **Timeout.** `resp_type`=1, CMD line left pulled high → `timeout`=1 after 64 rise ticks, then `done` after 8 more, with `resp`=0.
- **Long response.** CMD2 with `resp_type`=2, model returns a CID → `resp[127:0]` matches the model's CID frame bits 127:0, `crc_err`=0.
- **Control.** Assert `start` while `busy` → no effect on the frame. Assert `rst` at bit 20 of TX → `mc_cmd_oe`=0 and `busy`=0 the next cycle, and no `done`.
